// File: rtl/twiddle_pkg.sv
// Shared definitions for the twiddle-factor generator: quarter-wave sine
// table entries, quadrant encoding and the quadrant fold used to turn a
// (quadrant, offset) pair into signed cosine/sine values.
package twiddle_pkg;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  localparam real TWO_PI = 6.283185307179586476925;

  // Entry m of the quarter table: trunc(2^frac_w * sin(2*pi*m / 2^log2_n)).
  // Only evaluated at elaboration time to build constant ROM contents.
  function automatic int unsigned quarter_sin(input int log2_n, input int frac_w,
                                              input int m);
    real ang;
    ang = TWO_PI * real'(m) / real'(1 << log2_n);
    return $rtoi(real'(1 << frac_w) * $sin(ang));
  endfunction

  // Cosine from the quarter-table reads S[r] and S[Q-r].
  function automatic int fold_cos(input quad_e q, input int s_r, input int s_qr);
    int c;
    case (q)
      QUAD_0:  c = s_qr;
      QUAD_1:  c = -s_r;
      QUAD_2:  c = -s_qr;
      default: c = s_r;
    endcase
    return c;
  endfunction

  // Sine from the quarter-table reads S[r] and S[Q-r].
  function automatic int fold_sin(input quad_e q, input int s_r, input int s_qr);
    int s;
    case (q)
      QUAD_0:  s = s_r;
      QUAD_1:  s = s_qr;
      QUAD_2:  s = -s_r;
      default: s = -s_qr;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Request/result handshake bundle between the address sequencer, the
// twiddle generator and the complex multiplier.
// slave = the generator, master = the side driving requests / taking results.
interface twiddle_gen_if #(
  parameter int LOG2_N = 5,
  parameter int DATA_W = 16
) ();
  localparam int SW = $clog2(LOG2_N + 1);

  logic              req_valid;
  logic              req_ready;
  logic [SW-1:0]     req_stage;
  logic [LOG2_N-1:0] req_idx;
  logic              req_inv;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic              out_err;

  modport master (
    output req_valid, req_stage, req_idx, req_inv, out_ready,
    input  req_ready, out_valid, out_re, out_im, out_err
  );

  modport slave (
    input  req_valid, req_stage, req_idx, req_inv, out_ready,
    output req_ready, out_valid, out_re, out_im, out_err
  );
endinterface

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave sine table, Q+1 unsigned words, two registered read ports.
// Latency: 1 cycle from address to data when en is high.
// Backpressure: en low holds both read registers; data path has no reset.
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int LOG2_N = 5,
  parameter int FRAC_W = 8,
  localparam int Q  = 1 << (LOG2_N - 2),
  localparam int AW = $clog2(Q + 1),
  localparam int W  = FRAC_W + 1
) (
  input  logic          clk,
  input  logic          en,
  input  logic [AW-1:0] addr_r,
  input  logic [AW-1:0] addr_qr,
  output logic [W-1:0]  data_r,
  output logic [W-1:0]  data_qr
);

  logic [W-1:0] rom [0:Q];

  for (genvar m = 0; m <= Q; m++) begin : g_rom
    localparam logic [W-1:0] VAL = W'(quarter_sin(LOG2_N, FRAC_W, m));
    assign rom[m] = VAL;
  end

  // Both reads advance together with the pipeline stage they belong to.
  always_ff @(posedge clk) begin
    if (en) begin
      data_r  <= rom[addr_r];
      data_qr <= rom[addr_qr];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor generator: W = cos -/+ j*sin for stage s, index j from one quarter table.
// Latency: 3 register stages (fold/address, ROM read, sign/output), 1 result per cycle.
// Backpressure: per-stage valid bits; req_ready is combinational from out_ready, bubbles collapse.
module twiddle_gen
  import twiddle_pkg::*;
#(
  parameter int LOG2_N = 5,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  twiddle_gen_if.slave bus
);

  localparam int SW = $clog2(LOG2_N + 1);
  localparam int Q  = 1 << (LOG2_N - 2);
  localparam int AW = $clog2(Q + 1);
  localparam logic [SW-1:0]     MAX_STAGE = SW'(LOG2_N);
  localparam logic [LOG2_N-1:0] R_MASK    = LOG2_N'(Q - 1);
  localparam logic [AW-1:0]     Q_ADDR    = AW'(Q);

  logic en1, en2, en3;

  // Request decode
  logic              in_err;
  logic [LOG2_N-1:0] idx_mask;
  logic [LOG2_N-1:0] k;
  logic [AW-1:0]     r_in;
  quad_e             quad_in;

  // P1
  logic          v1, inv1, err1;
  logic [AW-1:0] r_addr1, qr_addr1;
  quad_e         quad1;

  // P2
  logic              v2, inv2, err2;
  quad_e             quad2;
  logic [FRAC_W:0]   s_r2, s_qr2;

  // P3 / outputs
  logic signed [DATA_W-1:0] cos_w, sin_w, re_n, im_n;
  logic                     out_valid_q, out_err_q;
  logic [DATA_W-1:0]        out_re_q, out_im_q;

  assign en3 = !out_valid_q || bus.out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;

  assign bus.req_ready = en1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_err   = out_err_q;

  // Map (stage, index) onto the full-size circle and split into quadrant/offset.
  always_comb begin
    in_err   = bus.req_stage > MAX_STAGE;
    idx_mask = LOG2_N'((32'd1 << bus.req_stage) - 32'd1);
    k        = '0;
    if (!in_err) k = (bus.req_idx & idx_mask) << (MAX_STAGE - bus.req_stage);
    r_in     = AW'(k & R_MASK);
    quad_in  = quad_e'(k[LOG2_N-1 -: 2]);
  end

  // P1: fold addresses and request sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      r_addr1  <= '0;
      qr_addr1 <= '0;
      quad1    <= QUAD_0;
      inv1     <= 1'b0;
      err1     <= 1'b0;
    end else if (en1) begin
      v1       <= bus.req_valid;
      r_addr1  <= r_in;
      qr_addr1 <= Q_ADDR - r_in;
      quad1    <= quad_in;
      inv1     <= bus.req_inv;
      err1     <= in_err;
    end
  end

  twiddle_quarter_rom #(
    .LOG2_N (LOG2_N),
    .FRAC_W (FRAC_W)
  ) u_rom (
    .clk     (clk),
    .en      (en2),
    .addr_r  (r_addr1),
    .addr_qr (qr_addr1),
    .data_r  (s_r2),
    .data_qr (s_qr2)
  );

  // P2: sideband travels alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      quad2 <= QUAD_0;
      inv2  <= 1'b0;
      err2  <= 1'b0;
    end else if (en2) begin
      v2    <= v1;
      quad2 <= quad1;
      inv2  <= inv1;
      err2  <= err1;
    end
  end

  // Quadrant fold, conjugation for forward transforms, error masking.
  always_comb begin
    cos_w = DATA_W'(fold_cos(quad2, int'(s_r2), int'(s_qr2)));
    sin_w = DATA_W'(fold_sin(quad2, int'(s_r2), int'(s_qr2)));
    re_n  = cos_w;
    im_n  = inv2 ? sin_w : -sin_w;
    if (err2) begin
      re_n = '0;
      im_n = '0;
    end
  end

  // P3: output registers, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_err_q   <= 1'b0;
    end else if (en3) begin
      out_valid_q <= v2;
      out_re_q    <= re_n;
      out_im_q    <= im_n;
      out_err_q   <= err2;
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen (LOG2_N=5, DATA_W=16, FRAC_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-computed, except the sweep, which uses a real-valued model.
module tb_twiddle_gen;

  localparam int LOG2_N = 5;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int SW     = $clog2(LOG2_N + 1);
  localparam real PI    = 3.14159265358979323846;
  localparam int TOT    = 6 * 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  twiddle_gen_if #(.LOG2_N(LOG2_N), .DATA_W(DATA_W)) bus ();

  twiddle_gen #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // sweep / stall bookkeeping
  logic [32:0] expq [$];
  logic [32:0] held, cur, expv;
  bit          was_held;
  int          sidx, got, cyc, acc, ridx;
  int          s_v, j_v;
  bit          inv_v;
  int          st_s [4] = '{6, 5, 2, 1};
  int          st_j [4] = '{3, 1, 3, 1};
  bit          st_i [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit v, input int s, input int j, input bit inv);
    bus.req_valid = v;
    bus.req_stage = SW'(s);
    bus.req_idx   = LOG2_N'(j);
    bus.req_inv   = inv;
  endtask

  function automatic logic [32:0] outs();
    return {bus.out_re, bus.out_im, bus.out_err};
  endfunction

  // Truncated cos/sin of the full-size angle; {re, im, err}.
  function automatic logic [32:0] model(input int s, input int j, input bit inv);
    int  k, c, sn;
    real th;
    logic [15:0] re, im;
    if (s > LOG2_N) return {16'h0000, 16'h0000, 1'b1};
    k  = (j % (1 << s)) * (1 << (LOG2_N - s));
    th = 2.0 * PI * real'(k) / 32.0;
    c  = $rtoi(256.0 * $cos(th));
    sn = $rtoi(256.0 * $sin(th));
    re = 16'(c);
    im = inv ? 16'(sn) : 16'(-sn);
    return {re, im, 1'b0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_req(0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.out_valid, outs()}, 34'h0);
    chk("reset_req_ready", bus.req_ready, 1);
    rst_n = 1'b1;

    // Forward s=5 j=8: quadrant 1 boundary -> (0, -1.0)
    @(negedge clk); set_req(1, 5, 8, 0);
    #1 chk("t1_accept", bus.req_ready, 1);
    @(negedge clk); set_req(0, 0, 0, 0);
    chk("t1_lat_e1", bus.out_valid, 0);
    @(negedge clk); chk("t1_lat_e2", bus.out_valid, 0);
    @(negedge clk); chk("t1_valid_e3", bus.out_valid, 1);
    chk("t1_data", outs(), {16'h0000, 16'hFF00, 1'b0});
    @(negedge clk); chk("t1_drained", bus.out_valid, 0);

    // Back to back: s=5 j=4 and s=3 j=1 map to the same global index
    @(negedge clk); set_req(1, 5, 4, 0);
    @(negedge clk); set_req(1, 3, 1, 0);
    @(negedge clk); set_req(0, 0, 0, 0);
    @(negedge clk); chk("t2a_valid", bus.out_valid, 1);
    chk("t2a_data", outs(), {16'h00B5, 16'hFF4B, 1'b0});
    @(negedge clk); chk("t2b_valid", bus.out_valid, 1);
    chk("t2b_data", outs(), {16'h00B5, 16'hFF4B, 1'b0});
    @(negedge clk); chk("t2_drained", bus.out_valid, 0);

    // Inverse s=5 j=20 (quadrant 2), then s=0 with index masked to 0
    @(negedge clk); set_req(1, 5, 20, 1);
    @(negedge clk); set_req(1, 0, 7, 1);
    @(negedge clk); set_req(0, 0, 0, 0);
    @(negedge clk); chk("t3a_data", {bus.out_valid, outs()}, {1'b1, 16'hFF4B, 16'hFF4B, 1'b0});
    @(negedge clk); chk("t3b_data", {bus.out_valid, outs()}, {1'b1, 16'h0100, 16'h0000, 1'b0});

    // Sweep all stages and indices with random consumer stalls
    sidx = 0; got = 0; cyc = 0; was_held = 0;
    while ((got < TOT) && (cyc < 4000)) begin
      @(negedge clk);
      cyc++;
      cur = outs();
      if (was_held) chk("sweep_hold", {bus.out_valid, cur}, {1'b1, held});
      was_held = 0;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          expv = 33'h1_FFFF_FFFF;
          if (expq.size() > 0) expv = expq.pop_front();
          chk("sweep_data", cur, expv);
          got++;
        end else begin
          held = cur;
          was_held = 1;
        end
      end
      if (sidx < TOT) begin
        s_v   = sidx / 32;
        j_v   = sidx % 32;
        inv_v = bit'((sidx ^ (sidx >> 3)) & 1);
        set_req(1, s_v, j_v, inv_v);
        #1;
        if (bus.req_ready) begin
          expq.push_back(model(s_v, j_v, inv_v));
          sidx++;
        end
      end else begin
        set_req(0, 0, 0, 0);
      end
    end
    chk("sweep_count", got, TOT);
    chk("sweep_leftover", expq.size(), 0);

    @(negedge clk); set_req(0, 0, 0, 0); bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_empty", bus.out_valid, 0);

    // Stall with out_ready low: error request first, pipeline fills with 3
    bus.out_ready = 1'b0;
    acc = 0; ridx = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      set_req(1, st_s[ridx], st_j[ridx], st_i[ridx]);
      #1;
      if (bus.req_ready) begin
        acc++;
        if (ridx < 3) ridx++;
      end
    end
    @(negedge clk);
    chk("stall_accepted", acc, 3);
    chk("stall_req_ready", bus.req_ready, 0);
    chk("stall_err_out", {bus.out_valid, outs()}, {1'b1, 16'h0000, 16'h0000, 1'b1});
    set_req(0, 0, 0, 0);
    bus.out_ready = 1'b1;
    #1 chk("stall_release_ready", bus.req_ready, 1);
    @(negedge clk);
    chk("stall_r2", {bus.out_valid, outs()}, {1'b1, 16'h00FB, 16'hFFCF, 1'b0});
    @(negedge clk);
    chk("stall_r3", {bus.out_valid, outs()}, {1'b1, 16'h0000, 16'hFF00, 1'b0});
    @(negedge clk);
    chk("stall_drained", bus.out_valid, 0);

    // Asynchronous reset with requests in flight
    @(negedge clk); set_req(1, 5, 1, 0);
    @(negedge clk); set_req(1, 5, 4, 0);
    @(negedge clk); set_req(1, 3, 1, 0);
    @(negedge clk); set_req(0, 0, 0, 0);
    chk("rst_pre_data", {bus.out_valid, outs()}, {1'b1, 16'h00FB, 16'hFFCF, 1'b0});
    #2 rst_n = 1'b0;
    #1 chk("rst_async_out", {bus.out_valid, outs()}, 34'h0);
    chk("rst_async_ready", bus.req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); set_req(1, 5, 20, 0);
    @(negedge clk); set_req(0, 0, 0, 0);
    chk("rst_new_e1", bus.out_valid, 0);
    @(negedge clk); chk("rst_new_e2", bus.out_valid, 0);
    @(negedge clk);
    chk("rst_new_e3", {bus.out_valid, outs()}, {1'b1, 16'hFF4B, 16'h00B5, 1'b0});
    @(negedge clk); chk("rst_no_ghost1", bus.out_valid, 0);
    @(negedge clk); chk("rst_no_ghost2", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
